// File: rtl/pw_pkg.sv
// Shared types and constants for the password checker slice.
// Used by the checker FSM and its byte selector.
package pw_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int          BYTE_W            = 8;
  localparam logic [7:0]  ASCII_A           = 8'h61;
  localparam int          DEFAULT_MAX_BYTES = 16;

  // Index width for a bus of n bytes; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pw_byte_mux.sv
// Combinational selector returning byte[index] of a MAX_BYTES-byte bus.
// Out-of-range indices return zero.
module pw_byte_mux
  import pw_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES,
  parameter int IDX_W     = idx_width(DEFAULT_MAX_BYTES)
) (
  input  logic [BYTE_W*MAX_BYTES-1:0] bus,
  input  logic [IDX_W-1:0]            index,
  output logic [BYTE_W-1:0]           data
);

  // Byte select with a guard for indices past the end of the bus.
  always_comb begin
    data = {BYTE_W{1'b0}};
    if (int'(index) < MAX_BYTES) begin
      data = bus[int'(index)*BYTE_W +: BYTE_W];
    end else begin
      data = {BYTE_W{1'b0}};
    end
  end

endmodule

// File: rtl/password_checker.sv
// Paces the candidate generator, captures each candidate and compares it
// byte-serially against the target, latching the first match.
module password_checker
  import pw_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES,
  parameter int CNT_W     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [BYTE_W*MAX_BYTES-1:0]  target_password,
  input  logic [7:0]                   target_length,
  input  logic [BYTE_W*MAX_BYTES-1:0]  candidate,
  input  logic [7:0]                   candidate_length,
  output logic                         ready,
  output logic                         busy,
  output logic                         found,
  output logic [BYTE_W*MAX_BYTES-1:0]  found_password,
  output logic [CNT_W-1:0]             attempts
);

  localparam int         BUS_W    = BYTE_W * MAX_BYTES;
  localparam int         IDX_W    = idx_width(MAX_BYTES);
  localparam logic [8:0] MAX_BITS = 9'(BYTE_W * MAX_BYTES);

  state_t               state_r;
  logic [BUS_W-1:0]     cand_r;
  logic [BUS_W-1:0]     tgt_r;
  logic [7:0]           cand_len_r;
  logic [7:0]           tgt_len_r;
  logic [IDX_W-1:0]     idx_r;

  logic [BYTE_W-1:0]    cand_byte_s;
  logic [BYTE_W-1:0]    tgt_byte_s;
  logic                 len_ok_s;
  logic                 byte_eq_s;
  logic                 is_last_s;
  logic [7:0]           last_idx_s;

  pw_byte_mux #(.MAX_BYTES(MAX_BYTES), .IDX_W(IDX_W)) u_cand_mux (
    .bus   (cand_r),
    .index (idx_r),
    .data  (cand_byte_s)
  );

  pw_byte_mux #(.MAX_BYTES(MAX_BYTES), .IDX_W(IDX_W)) u_tgt_mux (
    .bus   (tgt_r),
    .index (idx_r),
    .data  (tgt_byte_s)
  );

  // Length legality of the live generator inputs, judged at capture time.
  always_comb begin
    len_ok_s = 1'b0;
    if ((candidate_length == target_length) &&
        (candidate_length != 8'd0) &&
        (candidate_length[2:0] == 3'd0) &&
        ({1'b0, candidate_length} <= MAX_BITS)) begin
      len_ok_s = 1'b1;
    end else begin
      len_ok_s = 1'b0;
    end
  end

  // Per-byte compare on the registered copies; last byte is length/8-1.
  always_comb begin
    last_idx_s = (tgt_len_r >> 3) - 8'd1;
    is_last_s  = (8'(idx_r) == last_idx_s);
    byte_eq_s  = (cand_byte_s == tgt_byte_s) && (cand_len_r == tgt_len_r);
  end

  // Control FSM with registered outputs, capture registers and attempt counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      ready          <= 1'b0;
      busy           <= 1'b0;
      found          <= 1'b0;
      found_password <= {BUS_W{1'b0}};
      attempts       <= {CNT_W{1'b0}};
      cand_r         <= {BUS_W{1'b0}};
      tgt_r          <= {BUS_W{1'b0}};
      cand_len_r     <= 8'd0;
      tgt_len_r      <= 8'd0;
      idx_r          <= {IDX_W{1'b0}};
    end else begin
      ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= REQ;
            ready   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        REQ: begin
          state_r <= CAPTURE;
          busy    <= 1'b1;
        end

        CAPTURE: begin
          cand_r     <= candidate;
          tgt_r      <= target_password;
          cand_len_r <= candidate_length;
          tgt_len_r  <= target_length;
          idx_r      <= {IDX_W{1'b0}};
          if (attempts != {CNT_W{1'b1}}) begin
            attempts <= attempts + CNT_W'(1);
          end else begin
            attempts <= attempts;
          end
          if (len_ok_s) begin
            state_r <= COMPARE;
            busy    <= 1'b1;
          end else if (enable) begin
            state_r <= REQ;
            ready   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end

        COMPARE: begin
          if (!byte_eq_s) begin
            if (enable) begin
              state_r <= REQ;
              ready   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else if (is_last_s) begin
            state_r        <= DONE;
            busy           <= 1'b0;
            found          <= 1'b1;
            found_password <= cand_r;
          end else begin
            state_r <= COMPARE;
            busy    <= 1'b1;
            idx_r   <= idx_r + IDX_W'(1);
          end
        end

        DONE: begin
          state_r <= DONE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Downstream consumer of the brute-force candidate generator. Paces the generator with a one-cycle ready pulse and captures each 128-bit candidate and its bit-length.
- Compares each candidate byte-serially against a target password, with early exit on mismatch. Latches the first match and reports it with a saturating attempt count.
- Sits between the generator and the top-level controller / display.

Parameters:
MAX_BYTES, 16, maximum password length in bytes; bus width is 8*MAX_BYTES.
CNT_W, 32, width of the attempt counter.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous reset, active-high.
enable  in  1  run request from the controller.
target_password  in  8*MAX_BYTES  password to find; byte i is bits [8i+7:8i].
target_length  in  8  target length in bits; must be a multiple of 8.
candidate  in  8*MAX_BYTES  candidate from the generator; same byte order as target_password.
candidate_length  in  8  candidate length in bits, as counted by the generator.
ready  out  1  one-cycle request to the generator to present the next candidate.
busy  out  1  high in every state except IDLE and DONE.
found  out  1  sticky match flag.
found_password  out  8*MAX_BYTES  matching candidate; zero until found.
attempts  out  CNT_W  number of candidates captured; saturates at all-ones.

Behaviour:
- Reset (synchronous, overrides everything, legal in any state):
  - state goes to IDLE.
  - ready, busy, found = 0; found_password = 0; attempts = 0.
  - Internal candidate/target/length registers and byte index = 0.
- States: IDLE, REQ, CAPTURE, COMPARE, DONE.
- IDLE: ready=0. If enable=1, go to REQ; otherwise stay.
- REQ: ready=1 for exactly this cycle. The generator updates its password on this edge. Next state is CAPTURE.
- CAPTURE: register all of the following, and increment attempts (saturating):
  - candidate, candidate_length
  - target_password, target_length
  - byte index cleared to 0
- Validity check in CAPTURE. The candidate is rejected if any of these hold:
  - candidate_length != target_length
  - length == 0
  - length[2:0] != 0
  - length > 8*MAX_BYTES
- Reject from CAPTURE: go to REQ if enable=1, else IDLE. Otherwise go to COMPARE.
- COMPARE: one byte per cycle at the current index.
  - Byte mismatch: go to REQ if enable=1, else IDLE.
  - Byte match, index < length/8-1: increment index, stay in COMPARE.
  - Byte match, index == length/8-1: go to DONE. found <= 1 and found_password <= latched candidate on the same edge.
- Bytes at index >= length/8 are never compared; stale or nonzero upper bytes are ignored.
- DONE: ready=0, outputs held. Only reset leaves DONE; enable is ignored.
- enable falling mid-candidate: the current comparison completes, including a possible DONE. No further REQ is issued.
- Timing, per candidate, from REQ:
  - Length reject: 2 cycles.
  - Mismatch at byte k: 3+k cycles.
  - Full match of L bytes: 2+L cycles, with found visible after the last compare edge.
- ready is never high in two consecutive cycles.
- Comparison uses only the registered copies; input changes after CAPTURE have no effect on the candidate in flight.

Decomposition:
- Shared package pw_pkg holds:
  - state enum {IDLE, REQ, CAPTURE, COMPARE, DONE}
  - BYTE_W=8
  - ASCII_A=8'h61
  - default MAX_BYTES
- One natural sub-module: pw_byte_mux, a combinational selector returning byte[index] from a MAX_BYTES-byte bus. It is instantiated twice, for the candidate and the target. The FSM, attempt counter and result latches stay in password_checker.

Test Plan:
1. Reset: hold reset for 3 cycles with enable=1 -> ready=0, busy=0, found=0, attempts=0, found_password=0.
2. Full match: target 16'h6261 ("ab"), length 16; candidate 16'h6261, length 16; enable rises before edge 0 -> ready=1 in cycle 1, capture at edge 2, compare at edges 3-4, found=1 after edge 4, found_password=16'h6261, attempts=1. ready then stays 0 in DONE.
3. Mismatch: same target, candidate 16'h6263 held constant -> ready pulses every 3 cycles; attempts = 1, 2, 3, ...; found stays 0. Candidate 16'h6361 (second byte wrong) -> ready pulses every 4 cycles.
4. Length and illegal-length reject:
   - candidate_length=8 vs target 16 -> ready pulses every 2 cycles, no COMPARE entered.
   - Lengths 0, 12 and 136 -> rejected.
   - Target "a" with length 8 and candidate 128'hFFFF..61, length 8 -> match; upper bytes are ignored.
5. Mid-operation controls:
   - Drop enable during COMPARE of a matching candidate -> found=1, state DONE.
   - Drop enable during COMPARE of a non-matching candidate -> returns to IDLE, no further ready pulses.
   - Assert reset mid-COMPARE -> all outputs cleared on the next edge.
6. Saturation: set CNT_W=4 and present 20 rejected candidates -> attempts stops at 4'hF and does not wrap.
